// File: rtl/rv32i_mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// major opcodes, datapath select codes and a few decode helpers.
package rv32i_mc_ctrl_pkg;

    localparam int INSTWIDTH = 32;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPRI     = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] PC_SEL_PLUS4     = 2'd0;
    localparam logic [1:0] PC_SEL_OLDPC_IMM = 2'd1;
    localparam logic [1:0] PC_SEL_RS1_IMM   = 2'd2;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] ALU_A_RS1   = 2'd0;
    localparam logic [1:0] ALU_A_OLDPC = 2'd1;
    localparam logic [1:0] ALU_A_ZERO  = 2'd2;

    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    localparam logic [3:0] ALU_OP_ADD = 4'b0000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;

    function automatic logic is_mem_op(input logic [6:0] opc);
        return (opc == OPC_LOAD) || (opc == OPC_STORE);
    endfunction

endpackage

// File: rtl/rv32i_alu_dec.sv
// ALU operand/operation decode and illegal-instruction detection, purely
// combinational from the latched IR and the current FSM state.
module rv32i_alu_dec
    import rv32i_mc_ctrl_pkg::*;
(
    input  logic [INSTWIDTH-1:0] i_ir,
    input  state_t               i_state,
    output logic [3:0]           o_alu_op,
    output logic [1:0]           o_alu_a_sel,
    output logic                 o_alu_b_sel,
    output logic                 o_illegal
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic [2:0] w_funct3;
    logic       w_operands_live;
    logic       w_unused_ir;

    assign w_opcode    = i_ir[6:0];
    assign w_funct7    = i_ir[31:25];
    assign w_funct3    = i_ir[14:12];
    assign w_unused_ir = ^{i_ir[24:15], i_ir[11:7]};

    // Operand selects stay valid from EXEC through MEM/WB so the address and result hold.
    assign w_operands_live = (i_state == ST_EXEC) || (i_state == ST_MEM) || (i_state == ST_WB);

    always_comb begin
        o_illegal = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_MISC_MEM: o_illegal = 1'b0;
            OPC_OP: begin
                if (w_funct7 == F7_ALT)
                    o_illegal = (w_funct3 != F3_ADD_SUB) && (w_funct3 != F3_SRL_SRA);
                else
                    o_illegal = (w_funct7 != F7_BASE);
            end
            OPC_OPRI: begin
                if (w_funct3 == F3_SLL)
                    o_illegal = (w_funct7 != F7_BASE);
                else if (w_funct3 == F3_SRL_SRA)
                    o_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
            end
            OPC_SYSTEM: o_illegal = 1'b1;
            default:    o_illegal = 1'b1;
        endcase
    end

    always_comb begin
        o_alu_op    = ALU_OP_ADD;
        o_alu_a_sel = ALU_A_RS1;
        o_alu_b_sel = ALU_B_RS2;
        if (w_operands_live) begin
            case (w_opcode)
                OPC_LUI: begin
                    o_alu_a_sel = ALU_A_ZERO;
                    o_alu_b_sel = ALU_B_IMM;
                end
                OPC_AUIPC, OPC_JAL, OPC_BRANCH: begin
                    o_alu_a_sel = ALU_A_OLDPC;
                    o_alu_b_sel = ALU_B_IMM;
                end
                OPC_OP: o_alu_op = {i_ir[30], w_funct3};
                OPC_OPRI: begin
                    // ir[30] is immediate data except for SRLI/SRAI
                    o_alu_b_sel = ALU_B_IMM;
                    o_alu_op    = {(w_funct3 == F3_SRL_SRA) & i_ir[30], w_funct3};
                end
                OPC_LOAD, OPC_STORE, OPC_JALR: o_alu_b_sel = ALU_B_IMM;
                default: o_alu_op = ALU_OP_ADD;
            endcase
        end
    end

endmodule

// File: rtl/rv32i_mc_ctrl.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/exec/mem/wb over a
// single-port req/ack memory and traps on illegal opcodes or memory timeout.
module rv32i_mc_ctrl
    import rv32i_mc_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TO_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTWIDTH-1:0] i_ir,
    input  logic                 i_br_taken,
    input  logic                 i_mem_ack,
    output logic                 o_ir_we,
    output logic                 o_pc_we,
    output logic [1:0]           o_pc_sel,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic                 o_mem_addr_sel,
    output logic [1:0]           o_alu_a_sel,
    output logic                 o_alu_b_sel,
    output logic [3:0]           o_alu_op,
    output logic                 o_rf_we,
    output logic [1:0]           o_wb_sel,
    output logic                 o_illegal,
    output logic                 o_bus_err,
    output logic [2:0]           o_state
);

    state_t              r_state;
    logic                r_illegal;
    logic                r_bus_err;
    logic [TO_WIDTH-1:0] r_to_cnt;

    logic [6:0]          w_opcode;
    logic                w_dec_illegal;
    logic                w_waiting;
    logic [TO_WIDTH-1:0] w_to_cnt_next;
    logic                w_timeout;

    assign w_opcode = i_ir[6:0];

    rv32i_alu_dec u_alu_dec (
        .i_ir        (i_ir),
        .i_state     (r_state),
        .o_alu_op    (o_alu_op),
        .o_alu_a_sel (o_alu_a_sel),
        .o_alu_b_sel (o_alu_b_sel),
        .o_illegal   (w_dec_illegal)
    );

    // Timeout fires on the edge where the wait count would reach TIMEOUT_CYCLES; an ack that cycle wins.
    assign w_waiting     = o_mem_req && !i_mem_ack;
    assign w_to_cnt_next = r_to_cnt + TO_WIDTH'(1);
    assign w_timeout     = (TIMEOUT_CYCLES != 0) && w_waiting
                           && (w_to_cnt_next == TO_WIDTH'(TIMEOUT_CYCLES));

    always_comb begin
        o_ir_we        = 1'b0;
        o_pc_we        = 1'b0;
        o_pc_sel       = PC_SEL_PLUS4;
        o_mem_req      = 1'b0;
        o_mem_we       = 1'b0;
        o_mem_addr_sel = 1'b0;
        o_rf_we        = 1'b0;
        o_wb_sel       = WB_SEL_ALU;
        case (r_state)
            ST_FETCH: begin
                o_mem_req = 1'b1;
                o_ir_we   = i_mem_ack;
                o_pc_we   = i_mem_ack;
            end
            ST_EXEC: begin
                case (w_opcode)
                    OPC_BRANCH: begin
                        o_pc_we  = i_br_taken;
                        o_pc_sel = PC_SEL_OLDPC_IMM;
                    end
                    OPC_JAL: begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = PC_SEL_OLDPC_IMM;
                    end
                    OPC_JALR: begin
                        o_pc_we  = 1'b1;
                        o_pc_sel = PC_SEL_RS1_IMM;
                    end
                    default: o_pc_we = 1'b0;
                endcase
            end
            ST_MEM: begin
                o_mem_req      = 1'b1;
                o_mem_addr_sel = 1'b1;
                o_mem_we       = (w_opcode == OPC_STORE);
            end
            ST_WB: begin
                o_rf_we = 1'b1;
                if (w_opcode == OPC_LOAD)
                    o_wb_sel = WB_SEL_MEM;
                else if ((w_opcode == OPC_JAL) || (w_opcode == OPC_JALR))
                    o_wb_sel = WB_SEL_LINK;
            end
            default: o_rf_we = 1'b0;
        endcase
        // Enables must drop the moment reset asserts, not at the next edge.
        if (!rst_n) begin
            o_ir_we   = 1'b0;
            o_pc_we   = 1'b0;
            o_mem_req = 1'b0;
            o_mem_we  = 1'b0;
            o_rf_we   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_FETCH;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            r_to_cnt <= w_waiting ? w_to_cnt_next : '0;
            case (r_state)
                ST_FETCH: begin
                    if (i_mem_ack) begin
                        r_state <= ST_DECODE;
                    end else if (w_timeout) begin
                        r_state   <= ST_TRAP;
                        r_bus_err <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_dec_illegal) begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end else if (w_opcode == OPC_MISC_MEM) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_mem_op(w_opcode))
                        r_state <= ST_MEM;
                    else if (w_opcode == OPC_BRANCH)
                        r_state <= ST_FETCH;
                    else
                        r_state <= ST_WB;
                end
                ST_MEM: begin
                    if (i_mem_ack) begin
                        r_state <= (w_opcode == OPC_STORE) ? ST_FETCH : ST_WB;
                    end else if (w_timeout) begin
                        r_state   <= ST_TRAP;
                        r_bus_err <= 1'b1;
                    end
                end
                ST_WB:   r_state <= ST_FETCH;
                ST_TRAP: r_state <= ST_TRAP;
                default: r_state <= ST_TRAP;
            endcase
        end
    end

    assign o_illegal = r_illegal;
    assign o_bus_err = r_bus_err;
    assign o_state   = r_state;

endmodule
